// File: rtl/layer_fifo.sv
// rtl/layer_fifo.sv - inter-layer pixel FIFO between two convolution stages
//
// Buffers pixels from the upstream conv layer and presents them to the
// downstream layer's line buffer. Storage is a simple dual-port RAM with a
// registered read port, so it maps onto block RAM.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   wr_data      pixel word from the upstream layer (o_data)
//   wr_en        write strobe from the upstream layer (o_valid)
//   rd_en        read request from the downstream layer (fifo_rd_en)
//   o_data       read pixel to the downstream layer (i_data), held when idle
//   o_valid      o_data valid, one cycle after an accepted read (i_valid)
//   almost_full  backpressure to the upstream layer (fifo_almost_full)
//   full         occupancy == DEPTH
//   empty        occupancy == 0
//   count        current occupancy
//   overflow     sticky: a write was dropped because the FIFO was full

module layer_fifo #(
    parameter int DATA_WIDTH        = 16,
    parameter int CHANNEL           = 8,
    parameter int DEPTH             = 512,
    parameter int ALMOST_FULL_THRES = DEPTH - 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH*CHANNEL-1:0]       wr_data,
    input  logic                                wr_en,
    input  logic                                rd_en,
    output logic [DATA_WIDTH*CHANNEL-1:0]       o_data,
    output logic                                o_valid,
    output logic                                almost_full,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                overflow
);

    localparam int W  = DATA_WIDTH * CHANNEL;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRES);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    // Flags come from the registered count only, so acceptance below always
    // sees the state at the start of the cycle: a read does not make room
    // for a same-cycle write, and a write cannot fall through to a
    // same-cycle read.
    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_C);

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // RAM write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Registered RAM read port. Reset kills any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= rd_ok;
            if (rd_ok) begin
                o_data <= mem[rd_ptr];
            end
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_fifo.sv
// tb/tb_layer_fifo.sv - directed self-checking bench for layer_fifo

module tb_layer_fifo;

    localparam int DATA_WIDTH = 16;
    localparam int CHANNEL    = 8;
    localparam int DEPTH      = 16;
    localparam int AF_THRES   = 12;
    localparam int W          = DATA_WIDTH * CHANNEL;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  wr_data;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          almost_full;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic          overflow;

    int vectors     = 0;
    int miscompares = 0;

    layer_fifo #(
        .DATA_WIDTH        (DATA_WIDTH),
        .CHANNEL           (CHANNEL),
        .DEPTH             (DEPTH),
        .ALMOST_FULL_THRES (AF_THRES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .almost_full (almost_full),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_data = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_o_valid", W'(o_valid), W'(0));
        check("rst_o_data", o_data, W'(0));
        check("rst_count", W'(count), W'(0));
        check("rst_empty", W'(empty), W'(1));
        check("rst_full", W'(full), W'(0));
        check("rst_almost_full", W'(almost_full), W'(0));
        check("rst_overflow", W'(overflow), W'(0));

        // Idle with rd_en held high: nothing comes out.
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_o_valid", W'(o_valid), W'(0));
            check("idle_empty", W'(empty), W'(1));
            check("idle_count", W'(count), W'(0));
        end
        rd_en = 1'b0;

        // Write 1..5 then read them back with 1-cycle latency.
        wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_data = W'(i);
            tick();
            check("wr5_count", W'(count), W'(i));
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("rd5_o_valid", W'(o_valid), W'(1));
            check("rd5_o_data", o_data, W'(i));
        end
        rd_en = 1'b0;
        tick();
        check("rd5_done_o_valid", W'(o_valid), W'(0));
        check("rd5_hold_o_data", o_data, W'(5));
        check("rd5_count", W'(count), W'(0));

        // Fill to DEPTH, watch the thresholds, then overflow.
        wr_en = 1'b1;
        for (int n = 1; n <= DEPTH; n++) begin
            wr_data = W'(32'h100 + n - 1);
            tick();
            check("fill_count", W'(count), W'(n));
            check("fill_almost_full", W'(almost_full), W'(n >= AF_THRES));
            check("fill_full", W'(full), W'(n == DEPTH));
        end
        wr_data = W'(32'hDEAD);
        tick();
        check("ovf_overflow", W'(overflow), W'(1));
        check("ovf_count", W'(count), W'(DEPTH));
        wr_en = 1'b0;

        // Full with simultaneous read and write: write dropped, read proceeds.
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = W'(32'hBEEF);
        tick();
        check("fullrw_o_data", o_data, W'(32'h100));
        check("fullrw_count", W'(count), W'(DEPTH - 1));
        wr_en = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            tick();
            check("drain_o_valid", W'(o_valid), W'(1));
            check("drain_o_data", o_data, W'(32'h100 + k));
        end
        rd_en = 1'b0;
        tick();
        check("drain_o_valid_end", W'(o_valid), W'(0));
        check("drain_empty", W'(empty), W'(1));
        check("drain_overflow_sticky", W'(overflow), W'(1));

        // Simultaneous traffic at count=4 for 3*DEPTH cycles.
        wr_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wr_data = W'(32'h200 + j);
            tick();
        end
        check("rw_start_count", W'(count), W'(4));
        rd_en = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            wr_data = W'(32'h204 + k);
            tick();
            check("rw_count", W'(count), W'(4));
            check("rw_o_valid", W'(o_valid), W'(1));
            check("rw_o_data", o_data, W'(32'h200 + k));
        end
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rw_tail_o_data", o_data, W'(32'h200 + 3 * DEPTH + k));
        end
        rd_en = 1'b0;
        tick();
        check("rw_empty", W'(empty), W'(1));

        // Write into empty with rd_en in the same cycle: no fall-through.
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = W'(32'h55);
        tick();
        check("nft_o_valid", W'(o_valid), W'(0));
        check("nft_count", W'(count), W'(1));
        wr_en = 1'b0;
        tick();
        check("nft_rd_o_valid", W'(o_valid), W'(1));
        check("nft_rd_o_data", o_data, W'(32'h55));
        rd_en = 1'b0;
        tick();
        check("nft_count_end", W'(count), W'(0));

        // Reset in the middle of a read burst at count=8.
        wr_en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            wr_data = W'(32'h300 + j);
            tick();
        end
        wr_en = 1'b0;
        check("mid_count", W'(count), W'(8));
        rd_en = 1'b1;
        tick();
        tick();
        check("mid_o_data", o_data, W'(32'h301));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_o_valid", W'(o_valid), W'(0));
        check("mrst_count", W'(count), W'(0));
        check("mrst_empty", W'(empty), W'(1));
        check("mrst_overflow", W'(overflow), W'(0));
        rd_en = 1'b0;
        tick();
        check("mrst_o_valid_next", W'(o_valid), W'(0));
        wr_en   = 1'b1;
        wr_data = W'(32'h77);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("mrst_new_o_valid", W'(o_valid), W'(1));
        check("mrst_new_o_data", o_data, W'(32'h77));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
